data_memory_port: RTL and testbench

- Data-memory responder for the 16-bit pipelined CPU. It is the far end of the memory-write stage's MW_CPU_ON / WADDR_CPU / DATA_OUT_CPU store interface.
- Posts stores into a small write buffer, which drains into a single-port word RAM.
- Serves loads from the memory-read stage through a request/valid handshake, forwarding from the buffer where needed.
- Sits between the CPU pipeline and the on-chip data RAM.

---
 rtl/data_memory_port_pkg.sv | 20 ++
 rtl/data_memory_port_if.sv | 30 +++
 rtl/data_memory_port_wbuf_fifo.sv | 101 ++++++++++
 rtl/data_memory_port.sv | 124 ++++++++++++
 tb/tb_data_memory_port.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_port_pkg.sv
// cpu_defs: definitions shared by the data-memory port and the CPU pipeline.
//   DATA_W         datapath word width
//   OP_*           load/store opcodes of the 16-bit CPU
//   ST_*           load FSM state encodings
//   word_t         one data word
package cpu_defs;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_LW = 4'h8;
    localparam logic [3:0] OP_SW = 4'h9;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_EMPTY = 2'd1;
    localparam logic [1:0] ST_LOOKUP     = 2'd2;
    localparam logic [1:0] ST_RESP       = 2'd3;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/data_memory_port_if.sv
// data_memory_port_if: CPU <-> data-memory bus.
//   master (CPU side): drives the store strobe/address/data and the load
//                      request/address; receives load data, load-complete
//                      pulse and write-buffer status.
//   slave  (memory side): the reverse.
interface data_memory_port_if;
    import cpu_defs::*;

    logic              MW_CPU_ON;
    logic [DATA_W-1:0] WADDR_CPU;
    logic [DATA_W-1:0] DATA_OUT_CPU;
    logic              MR_CPU_ON;
    logic [DATA_W-1:0] RADDR_CPU;
    logic [DATA_W-1:0] DATA_IN_CPU;
    logic              RDATA_VALID;
    logic              WBUF_FULL;
    logic              WBUF_EMPTY;
    logic              DROP_ERR;

    modport master (
        output MW_CPU_ON, WADDR_CPU, DATA_OUT_CPU, MR_CPU_ON, RADDR_CPU,
        input  DATA_IN_CPU, RDATA_VALID, WBUF_FULL, WBUF_EMPTY, DROP_ERR
    );

    modport slave (
        input  MW_CPU_ON, WADDR_CPU, DATA_OUT_CPU, MR_CPU_ON, RADDR_CPU,
        output DATA_IN_CPU, RDATA_VALID, WBUF_FULL, WBUF_EMPTY, DROP_ERR
    );

endinterface

// File: rtl/data_memory_port_wbuf_fifo.sv
// wbuf_fifo: posted-store write buffer (circular FIFO of {addr, data}).
//   CLK, RST          clock, async active-high reset
//   push_req          store strobe; accepted only while not full
//   push_addr/data    store word address / data
//   drain_ok          RAM port available for a drain this cycle
//   drain_fire        oldest entry leaves this cycle (head_addr/head_data)
//   full/empty        registered from the post-update count
//   drop_err          sticky: a store arrived while full
//   lookup_addr       load address for the forwarding search
//   fwd_hit/fwd_data  youngest buffered entry matching lookup_addr
// Macro WBUF_FWD_EN: when undefined the search is not built and fwd_hit=0.
module wbuf_fifo
    import cpu_defs::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 push_req,
    input  logic [ADDR_BITS-1:0] push_addr,
    input  logic [DATA_W-1:0]    push_data,
    input  logic                 drain_ok,
    input  logic [ADDR_BITS-1:0] lookup_addr,
    output logic                 drain_fire,
    output logic [ADDR_BITS-1:0] head_addr,
    output logic [DATA_W-1:0]    head_data,
    output logic                 full,
    output logic                 empty,
    output logic                 drop_err,
    output logic                 fwd_hit,
    output logic [DATA_W-1:0]    fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_BITS-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0]    data_mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]     count, count_nxt;
    logic                 push_fire;

    // Acceptance uses the registered count: a full buffer rejects a store
    // even when a drain frees a slot in the same cycle.
    assign push_fire  = push_req && (count < DEPTH_C);
    assign drain_fire = drain_ok && (count != '0);
    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign count_nxt  = count + CNT_W'(push_fire) - CNT_W'(drain_fire);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            drop_err <= 1'b0;
        end else begin
            if (push_fire)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (drain_fire)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
            if (push_req && !push_fire)
                drop_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_fire) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

`ifdef WBUF_FWD_EN
    // Walk oldest to youngest so the last hit wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) &&
                (addr_mem[rd_ptr + PTR_W'(i)] == lookup_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[rd_ptr + PTR_W'(i)];
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = &{1'b0, lookup_addr};
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: rtl/data_memory_port.sv
// data_memory_port: data-memory responder for the 16-bit pipelined CPU.
// Stores are posted into a write buffer that drains into a single-port
// word RAM; loads use a request/valid handshake.
//   CLK, RST  clock, async active-high reset
//   bus       data_memory_port_if.slave (store, load and status signals)
// Macro WBUF_FWD_EN:
//   defined   loads forward from the buffer, fixed 2-cycle latency
//   undefined loads wait in WAIT_EMPTY until the buffer has drained
//
// state         | meaning
// --------------+------------------------------------------------------
// ST_IDLE       | no load in flight, waiting for MR_CPU_ON
// ST_WAIT_EMPTY | load pending, buffer draining (no-forward build only)
// ST_LOOKUP     | RAM read / forward check, drain stalled this cycle
// ST_RESP       | RDATA_VALID high for one cycle
module data_memory_port
    import cpu_defs::*;
#(
    parameter int ADDR_BITS  = 8,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    data_memory_port_if.slave bus
);

    logic [1:0]           state, state_nxt;
    logic [DATA_W-1:0]    ram [2**ADDR_BITS];
    logic [DATA_W-1:0]    rdata_q;
    logic [ADDR_BITS-1:0] raddr, waddr, drain_addr;
    logic [DATA_W-1:0]    drain_data, fwd_data;
    logic                 drain_ok, drain_fire, fwd_hit;
    logic                 full, empty, drop_err;
    logic                 unused_addr_hi;

    assign raddr = bus.RADDR_CPU[ADDR_BITS-1:0];
    assign waddr = bus.WADDR_CPU[ADDR_BITS-1:0];
    assign unused_addr_hi = &{1'b0, bus.RADDR_CPU[DATA_W-1:ADDR_BITS],
                              bus.WADDR_CPU[DATA_W-1:ADDR_BITS]};

    // The load read owns the single RAM port during LOOKUP.
    assign drain_ok = (state != ST_LOOKUP);

    wbuf_fifo #(
        .ADDR_BITS (ADDR_BITS),
        .DEPTH     (WBUF_DEPTH)
    ) u_wbuf (
        .CLK         (CLK),
        .RST         (RST),
        .push_req    (bus.MW_CPU_ON),
        .push_addr   (waddr),
        .push_data   (bus.DATA_OUT_CPU),
        .drain_ok    (drain_ok),
        .lookup_addr (raddr),
        .drain_fire  (drain_fire),
        .head_addr   (drain_addr),
        .head_data   (drain_data),
        .full        (full),
        .empty       (empty),
        .drop_err    (drop_err),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.MR_CPU_ON) begin
`ifdef WBUF_FWD_EN
                    state_nxt = ST_LOOKUP;
`else
                    state_nxt = ST_WAIT_EMPTY;
`endif
                end
            end
`ifndef WBUF_FWD_EN
            // A store arriving now would be buffered behind the read, so
            // it keeps the load waiting.
            ST_WAIT_EMPTY: if (empty && !bus.MW_CPU_ON) state_nxt = ST_LOOKUP;
`endif
            ST_LOOKUP: state_nxt = ST_RESP;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // A store enqueued during LOOKUP lands after this capture, so the load
    // sees the prior value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
        end else if (state == ST_LOOKUP) begin
`ifdef WBUF_FWD_EN
            rdata_q <= fwd_hit ? fwd_data : ram[raddr];
`else
            rdata_q <= ram[raddr];
`endif
        end
    end

`ifndef WBUF_FWD_EN
    logic unused_fwd;
    assign unused_fwd = &{1'b0, fwd_hit, fwd_data};
`endif

    always_ff @(posedge CLK) begin
        if (drain_fire)
            ram[drain_addr] <= drain_data;
    end

    assign bus.DATA_IN_CPU = rdata_q;
    assign bus.RDATA_VALID = (state == ST_RESP);
    assign bus.WBUF_FULL   = full;
    assign bus.WBUF_EMPTY  = empty;
    assign bus.DROP_ERR    = drop_err;

endmodule

// File: tb/tb_data_memory_port.sv
`timescale 1ns/1ps
module tb_data_memory_port;

    localparam int ADDR_BITS = 8;
    localparam int DEPTH     = 4;
`ifdef WBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int PH_IDLE   = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_LOOKUP = 2;
    localparam int PH_RESP   = 3;

    logic CLK = 1'b0;
    logic RST;

    data_memory_port_if bus_if();

    data_memory_port #(
        .ADDR_BITS  (ADDR_BITS),
        .WBUF_DEPTH (DEPTH)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;

    // Reference model: a logical memory (what a load must return), the RAM
    // image (what survives a reset) and the queue of stores not yet in RAM.
    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } st_t;

    st_t         pend[$];
    logic [15:0] mem_l [256];
    logic [15:0] ram_m [256];
    logic [15:0] m_rdata;
    bit          m_drop;
    int          ph;
    bit          ld_busy;
    logic [15:0] ld_addr;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_l[i] = ram_m[i];
        pend.delete();
        m_rdata = 16'h0;
        m_drop  = 1'b0;
        ph      = PH_IDLE;
        ld_busy = 1'b0;
    endtask

    task automatic model_step();
        bit         lookup_now, accept, drain, was_empty;
        st_t        e;
        logic [7:0] wa, ra;
        wa = bus_if.WADDR_CPU[7:0];
        ra = bus_if.RADDR_CPU[7:0];
        lookup_now = (ph == PH_LOOKUP);
        was_empty  = (pend.size() == 0);
        if (lookup_now) m_rdata = mem_l[ra];
        accept = bus_if.MW_CPU_ON && (pend.size() < DEPTH);
        if (bus_if.MW_CPU_ON && !accept) m_drop = 1'b1;
        drain = !lookup_now && !was_empty;
        if (drain) begin
            e = pend.pop_front();
            ram_m[e.a] = e.d;
        end
        if (accept) begin
            e.a = wa;
            e.d = bus_if.DATA_OUT_CPU;
            pend.push_back(e);
            mem_l[wa] = bus_if.DATA_OUT_CPU;
        end
        case (ph)
            PH_IDLE:   if (bus_if.MR_CPU_ON) ph = FWD ? PH_LOOKUP : PH_WAIT;
            PH_WAIT:   if (was_empty && !bus_if.MW_CPU_ON) ph = PH_LOOKUP;
            PH_LOOKUP: ph = PH_RESP;
            default:   ph = PH_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        chk("rdata_valid", 16'(bus_if.RDATA_VALID), 16'(ph == PH_RESP));
        chk("data_in",     bus_if.DATA_IN_CPU,      m_rdata);
        chk("wbuf_full",   16'(bus_if.WBUF_FULL),   16'(pend.size() == DEPTH));
        chk("wbuf_empty",  16'(bus_if.WBUF_EMPTY),  16'(pend.size() == 0));
        chk("drop_err",    16'(bus_if.DROP_ERR),    16'(m_drop));
    endtask

    // One clock: drive at the negedge, model at the posedge, check at the
    // next negedge. A load request is held until its RESP cycle is seen.
    task automatic cycle(input bit st, input logic [15:0] wa, input logic [15:0] wd,
                         input bit ld, input logic [15:0] ra);
        bus_if.MW_CPU_ON    = st;
        bus_if.WADDR_CPU    = wa;
        bus_if.DATA_OUT_CPU = wd;
        if (!ld_busy && ld) begin
            ld_busy = 1'b1;
            ld_addr = ra;
        end
        bus_if.MR_CPU_ON = ld_busy;
        bus_if.RADDR_CPU = ld_addr;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_outputs();
        if (ph == PH_RESP) ld_busy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic wait_load();
        int budget = 50;
        while (ld_busy && budget > 0) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            budget--;
        end
        chk("load_timeout", 16'(ld_busy), 16'h0);
    endtask

    task automatic do_load(input logic [15:0] a);
        cycle(1'b0, 16'h0, 16'h0, 1'b1, a);
        wait_load();
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        bus_if.MW_CPU_ON = 1'b0;
        bus_if.MR_CPU_ON = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_valid", 16'(bus_if.RDATA_VALID), 16'h0);
        chk("rst_empty", 16'(bus_if.WBUF_EMPTY),  16'h1);
        chk("rst_drop",  16'(bus_if.DROP_ERR),    16'h0);
        @(posedge CLK);
        @(negedge CLK);
        check_outputs();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0;
        bus_if.MW_CPU_ON    = 1'b0;
        bus_if.WADDR_CPU    = 16'h0;
        bus_if.DATA_OUT_CPU = 16'h0;
        bus_if.MR_CPU_ON    = 1'b0;
        bus_if.RADDR_CPU    = 16'h0;
        ld_addr = 16'h0;
        for (int i = 0; i < 256; i++) ram_m[i] = 16'h0;
        #1;
        pulse_reset();

        // Preload the words used by the random phase.
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i), 16'($urandom), 1'b0, 16'h0);
        idle(4);

        // Store then load three cycles later.
        cycle(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
        idle(2);
        do_load(16'h0010);
        chk("t1_data", bus_if.DATA_IN_CPU, 16'hBEEF);
        chk("t1_empty", 16'(bus_if.WBUF_EMPTY), 16'h1);

        // Back-to-back stores while loads keep taking the port.
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 16'(1 + i % 4), 16'h0A00 + 16'(i), 1'b1, 16'h0010);
        wait_load();
        idle(6);
        for (int a = 1; a <= 4; a++) do_load(16'(a));

        // Two stores to one address, immediate load: youngest wins.
        cycle(1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0);
        cycle(1'b1, 16'h0020, 16'h2222, 1'b0, 16'h0);
        do_load(16'h0020);
        chk("t3_data", bus_if.DATA_IN_CPU, 16'h2222);

        // Store in the load's LOOKUP cycle is not visible to that load.
        cycle(1'b1, 16'h0030, 16'h0005, 1'b0, 16'h0);
        idle(4);
        cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h0030);
        for (int n = 0; n < 20 && ld_busy; n++)
            cycle(ph == PH_LOOKUP, 16'h0030, 16'h7777, 1'b0, 16'h0);
        chk("t4_old", bus_if.DATA_IN_CPU, 16'h0005);
        idle(3);
        do_load(16'h0030);
        chk("t4_new", bus_if.DATA_IN_CPU, 16'h7777);

        // Upper address bits are ignored.
        cycle(1'b1, 16'h0105, 16'hABCD, 1'b0, 16'h0);
        idle(3);
        do_load(16'h0005);
        chk("t5_alias", bus_if.DATA_IN_CPU, 16'hABCD);
        do_load(16'hFF05);
        chk("t5_alias_hi", bus_if.DATA_IN_CPU, 16'hABCD);

        // Pointer wrap: ten push/drain cycles keep their order.
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'h0040 + 16'(i), 16'h5A00 + 16'(i), 1'b0, 16'h0);
        idle(4);
        for (int i = 0; i < 10; i++) begin
            do_load(16'h0040 + 16'(i));
            chk("t6_order", bus_if.DATA_IN_CPU, 16'h5A00 + 16'(i));
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++)
            cycle($urandom_range(0, 99) < 55,
                  {8'($urandom), 4'h0, 4'($urandom_range(0, 15))},
                  16'($urandom),
                  $urandom_range(0, 99) < 40,
                  {8'($urandom), 4'h0, 4'($urandom_range(0, 15))});
        wait_load();
        idle(6);

        // Reset while a load is in flight with stores buffered.
        cycle(1'b1, 16'h000A, 16'h1234, 1'b0, 16'h0);
        cycle(1'b1, 16'h000B, 16'h2345, 1'b0, 16'h0);
        cycle(1'b1, 16'h000C, 16'h3456, 1'b1, 16'h000A);
        pulse_reset();
        do_load(16'h000A);
        do_load(16'h000C);
        cycle(1'b1, 16'h000C, 16'h4567, 1'b0, 16'h0);
        idle(2);
        do_load(16'h000C);
        chk("t8_after_rst", bus_if.DATA_IN_CPU, 16'h4567);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
